// File: rtl/led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_seq
// Brief    : Steps a switch-selected LED animation once per slow-wave period,
//            with the slow wave sampled as data on the system clock.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_in,
    input  logic [2:0]       sw_mode,
    input  logic             sw_pause,
    output logic [WIDTH-1:0] led,
    output logic             step
);

    localparam logic [2:0] c_MODE_OFF    = 3'd0;
    localparam logic [2:0] c_MODE_SHL    = 3'd1;
    localparam logic [2:0] c_MODE_SHR    = 3'd2;
    localparam logic [2:0] c_MODE_BOUNCE = 3'd3;
    localparam logic [2:0] c_MODE_COUNT  = 3'd4;
    localparam logic [2:0] c_MODE_BLINK  = 3'd5;
    localparam logic [2:0] c_MODE_ALT    = 3'd6;
    localparam logic [2:0] c_MODE_FILL   = 3'd7;

    localparam logic c_DIR_LEFT  = 1'b0;
    localparam logic c_DIR_RIGHT = 1'b1;

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ALL  = '1;

    logic             r_s1, r_s2, r_s3;
    logic [2:0]       r_mode_m, r_mode_s;
    logic             r_pause_m, r_pause_s;
    logic [2:0]       r_mode_q;
    logic             r_dir;
    logic [WIDTH-1:0] r_led;
    logic             r_step;

    logic             w_step_raw;
    logic [WIDTH-1:0] w_alt_seed;
    logic [WIDTH-1:0] w_seed;
    logic [WIDTH-1:0] w_next;
    logic             w_next_dir;

    // Even bit positions lit: 0x55 at the default width.
    for (genvar i = 0; i < WIDTH; i++) begin : g_alt_seed
        assign w_alt_seed[i] = ((i % 2) == 0) ? 1'b1 : 1'b0;
    end

    assign w_step_raw = r_s2 & ~r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_mode_m  <= 3'd0;
            r_mode_s  <= 3'd0;
            r_pause_m <= 1'b0;
            r_pause_s <= 1'b0;
        end else begin
            r_s1      <= slow_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_mode_m  <= sw_mode;
            r_mode_s  <= r_mode_m;
            r_pause_m <= sw_pause;
            r_pause_s <= r_pause_m;
        end
    end

    always_comb begin
        w_seed = c_ZERO;
        case (r_mode_s)
            c_MODE_SHL:    w_seed = c_ONE;
            c_MODE_SHR:    w_seed = c_MSB;
            c_MODE_BOUNCE: w_seed = c_ONE;
            c_MODE_ALT:    w_seed = w_alt_seed;
            default:       w_seed = c_ZERO;
        endcase
    end

    always_comb begin
        w_next     = r_led;
        w_next_dir = r_dir;
        case (r_mode_q)
            c_MODE_OFF:   w_next = c_ZERO;
            c_MODE_SHL:   w_next = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
            c_MODE_SHR:   w_next = {r_led[0], r_led[WIDTH-1:1]};
            c_MODE_BOUNCE: begin
                // Turn around on the end LEDs so each end is lit once per pass.
                if (r_led == c_MSB) begin
                    w_next     = r_led >> 1;
                    w_next_dir = c_DIR_RIGHT;
                end else if ((r_led == c_ONE) && (r_dir == c_DIR_RIGHT)) begin
                    w_next     = r_led << 1;
                    w_next_dir = c_DIR_LEFT;
                end else if (r_dir == c_DIR_LEFT) begin
                    w_next = r_led << 1;
                end else begin
                    w_next = r_led >> 1;
                end
            end
            c_MODE_COUNT: w_next = r_led + c_ONE;
            c_MODE_BLINK: w_next = ~r_led;
            c_MODE_ALT:   w_next = ~r_led;
            c_MODE_FILL:  w_next = (r_led == c_ALL) ? c_ZERO : {r_led[WIDTH-2:0], 1'b1};
            default:      w_next = r_led;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q <= c_MODE_OFF;
            r_dir    <= c_DIR_LEFT;
            r_led    <= c_ZERO;
            r_step   <= 1'b0;
        end else if (r_mode_s != r_mode_q) begin
            // A step landing on a reload is dropped so the new seed is shown.
            r_mode_q <= r_mode_s;
            r_dir    <= c_DIR_LEFT;
            r_led    <= w_seed;
            r_step   <= 1'b0;
        end else if (w_step_raw && !r_pause_s) begin
            r_dir    <= w_next_dir;
            r_led    <= w_next;
            r_step   <= 1'b1;
        end else begin
            r_step   <= 1'b0;
        end
    end

    assign led  = r_led;
    assign step = r_step;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_seq
// Brief    : Directed, table-driven bench for led_pattern_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_seq;

    logic       clk;
    logic       rst;
    logic       slow_in;
    logic [2:0] sw_mode;
    logic       sw_pause;
    logic [7:0] led;
    logic       step;

    int checks;
    int errors;
    int step_seen;
    int base;

    typedef struct {
        logic [2:0] mode;
        logic       pause;
        int         pulses;
        logic [7:0] exp_led;
        int         exp_steps;
    } vec_t;

    vec_t vecs[$];

    led_pattern_seq #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .slow_in  (slow_in),
        .sw_mode  (sw_mode),
        .sw_pause (sw_pause),
        .led      (led),
        .step     (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step === 1'b1) step_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] m, input logic p, input int n,
                       input logic [7:0] l, input int s);
        vec_t v;
        v.mode = m; v.pause = p; v.pulses = n; v.exp_led = l; v.exp_steps = s;
        vecs.push_back(v);
    endtask

    task automatic pulse(input int hi, input int lo);
        @(negedge clk) slow_in = 1'b1;
        repeat (hi) @(negedge clk);
        slow_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            sw_mode  = vecs[i].mode;
            sw_pause = vecs[i].pause;
            repeat (6) @(negedge clk);
            base = step_seen;
            for (int k = 0; k < vecs[i].pulses; k++) pulse(4, 4);
            repeat (6) @(negedge clk);
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
            check($sformatf("vec%0d_steps", i), 32'(step_seen - base), 32'(vecs[i].exp_steps));
        end
    endtask

    int n_a;

    initial begin
        checks = 0; errors = 0; step_seen = 0; base = 0;

        // SHL wrap (first edge is checked by hand for latency)
        add(1, 0, 1, 8'h04, 1); add(1, 0, 1, 8'h08, 1); add(1, 0, 1, 8'h10, 1);
        add(1, 0, 1, 8'h20, 1); add(1, 0, 1, 8'h40, 1); add(1, 0, 1, 8'h80, 1);
        add(1, 0, 1, 8'h01, 1); add(1, 0, 1, 8'h02, 1);
        // BOUNCE
        add(3, 0, 0, 8'h01, 0);
        add(3, 0, 1, 8'h02, 1); add(3, 0, 1, 8'h04, 1); add(3, 0, 1, 8'h08, 1);
        add(3, 0, 1, 8'h10, 1); add(3, 0, 1, 8'h20, 1); add(3, 0, 1, 8'h40, 1);
        add(3, 0, 1, 8'h80, 1); add(3, 0, 1, 8'h40, 1); add(3, 0, 1, 8'h20, 1);
        add(3, 0, 1, 8'h10, 1); add(3, 0, 1, 8'h08, 1); add(3, 0, 1, 8'h04, 1);
        add(3, 0, 1, 8'h02, 1); add(3, 0, 1, 8'h01, 1); add(3, 0, 1, 8'h02, 1);
        add(3, 0, 1, 8'h04, 1);
        // COUNT
        add(4, 0, 0, 8'h00, 0); add(4, 0, 255, 8'hFF, 255); add(4, 0, 1, 8'h00, 1);
        // FILL
        add(7, 0, 0, 8'h00, 0);
        add(7, 0, 1, 8'h01, 1); add(7, 0, 1, 8'h03, 1); add(7, 0, 1, 8'h07, 1);
        add(7, 0, 1, 8'h0F, 1); add(7, 0, 1, 8'h1F, 1); add(7, 0, 1, 8'h3F, 1);
        add(7, 0, 1, 8'h7F, 1); add(7, 0, 1, 8'hFF, 1); add(7, 0, 1, 8'h00, 1);
        // BLINK, OFF, ALT with pause
        add(5, 0, 0, 8'h00, 0); add(5, 0, 1, 8'hFF, 1); add(5, 0, 1, 8'h00, 1);
        add(0, 0, 0, 8'h00, 0); add(0, 0, 2, 8'h00, 2);
        add(6, 0, 0, 8'h55, 0); add(6, 1, 3, 8'h55, 0); add(6, 0, 1, 8'hAA, 1);
        n_a = vecs.size();
        // SHR after the coincident reload
        add(2, 0, 1, 8'h40, 1); add(2, 0, 1, 8'h20, 1);

        rst = 1'b1; slow_in = 1'b1; sw_mode = 3'b001; sw_pause = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", 32'(led), 32'h00);
        check("rst_step", 32'(step), 32'h0);

        @(negedge clk) rst = 1'b0;
        base = step_seen;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reload_led", 32'(led), 32'h00);
        @(posedge clk); #1;
        check("reload_led", 32'(led), 32'h01);
        check("reload_step", 32'(step), 32'h0);
        // The stale-high slow_in step coincides with the reload and is dropped.
        repeat (10) @(negedge clk);
        check("stale_step_count", 32'(step_seen - base), 32'd0);
        check("stale_led", 32'(led), 32'h01);
        slow_in = 1'b0;
        repeat (6) @(negedge clk);

        // First SHL step: step high only in the cycle after the third edge
        @(negedge clk) slow_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("lat_e2_step", 32'(step), 32'h0);
        check("lat_e2_led", 32'(led), 32'h01);
        @(posedge clk); #1;
        check("lat_e3_step", 32'(step), 32'h1);
        check("lat_e3_led", 32'(led), 32'h02);
        @(posedge clk); #1;
        check("lat_e4_step", 32'(step), 32'h0);
        @(negedge clk) slow_in = 1'b0;
        repeat (4) @(negedge clk);

        run_vectors(0, n_a - 1);

        // Mode change in the same cycle step_raw fires
        @(negedge clk);
        sw_mode = 3'b010; slow_in = 1'b1;
        base = step_seen;
        repeat (3) @(posedge clk);
        #1;
        check("coinc_led", 32'(led), 32'h80);
        check("coinc_step", 32'(step), 32'h0);
        repeat (5) @(negedge clk);
        slow_in = 1'b0;
        repeat (5) @(negedge clk);
        check("coinc_steps", 32'(step_seen - base), 32'd0);
        check("coinc_led_hold", 32'(led), 32'h80);

        run_vectors(n_a, vecs.size() - 1);

        // Slow-wave robustness
        base = step_seen;
        pulse(1, 10);
        check("short_pulse_steps", 32'(step_seen - base), 32'd1);
        check("short_pulse_led", 32'(led), 32'h10);
        base = step_seen;
        @(negedge clk) slow_in = 1'b1;
        repeat (10000) @(negedge clk);
        check("long_high_steps", 32'(step_seen - base), 32'd1);
        check("long_high_led", 32'(led), 32'h08);
        base = step_seen;
        slow_in = 1'b0;
        repeat (10) @(negedge clk);
        check("fall_steps", 32'(step_seen - base), 32'd0);
        check("fall_led", 32'(led), 32'h08);

        // Reset landing on a pending step clears everything and loses the step
        base = step_seen;
        @(negedge clk) slow_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_led", 32'(led), 32'h00);
        check("midrst_step", 32'(step), 32'h0);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_reload_led", 32'(led), 32'h80);
        check("midrst_steps", 32'(step_seen - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
